// File: rtl/eater_pkg.sv
// Shared definitions for the 8-bit "eater" CPU slice: bus width defaults,
// instruction opcodes used by program images, and the loader state encoding.
package eater_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  // Opcodes occupy the high nibble of an instruction byte, operand the low nibble.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } loader_state_t;

  function automatic logic [7:0] make_instr(input logic [3:0] op, input logic [3:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/ram_loader_addr_ctr.sv
// Wrapping RAM address counter paired with a per-session transfer count;
// 'last' flags the final transfer of a session.
module ram_loader_addr_ctr #(
  parameter int ADDR_W     = 4,
  parameter int LOAD_COUNT = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int CNT_W = $clog2(LOAD_COUNT + 1);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOAD_COUNT - 1);

  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  count_r;

  // Restart at the base address on load, otherwise step once per transfer; address wraps naturally.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      addr_r  <= ADDR_BASE;
      count_r <= CNT_ZERO;
    end else if (inc) begin
      addr_r  <= addr_r + ADDR_ONE;
      count_r <= count_r + CNT_ONE;
    end else begin
      addr_r  <= addr_r;
      count_r <= count_r;
    end
  end

  assign addr = addr_r;
  assign last = (count_r == CNT_LAST);

endmodule

// File: rtl/ram_loader.sv
// Program loader: writes a valid/ready byte stream into consecutive RAM words
// while holding the CPU off the bus. Define RAM_LOADER_VERIFY_EN for a readback checksum pass.
module ram_loader
  import eater_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LOAD_COUNT = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              ri,
  output logic              ro,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(32'd0);

  loader_state_t     state_r;
  logic              busy_r;
  logic              in_ready_r;
  logic              done_r;
  logic [DATA_W-1:0] sum_r;

  logic              hs_s;
  logic              ctr_load_s;
  logic              ctr_inc_s;
  logic              last_s;
  logic [ADDR_W-1:0] addr_s;

`ifdef RAM_LOADER_VERIFY_EN
  logic              ro_r;
  logic              verify_err_r;
  logic [DATA_W-1:0] rsum_r;
  logic [DATA_W-1:0] rsum_next_s;

  assign rsum_next_s = rsum_r + mem_rdata;
`else
  logic              unused_rdata_s;

  assign unused_rdata_s = ^mem_rdata;
`endif

  // Write strobe and data follow the handshake directly so the RAM captures on this same edge.
  always_comb begin
    hs_s = in_valid & in_ready_r;
    ri   = hs_s;
    if (hs_s) begin
      mem_wdata = in_data;
    end else begin
      mem_wdata = DATA_ZERO;
    end
  end

  // Counter control: restart at session start (and before readback), step on each transfer.
  always_comb begin
    ctr_load_s = 1'b0;
    ctr_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          ctr_load_s = 1'b1;
        end else begin
          ctr_load_s = 1'b0;
        end
      end
      LOAD: begin
`ifdef RAM_LOADER_VERIFY_EN
        if (hs_s && last_s) begin
          ctr_load_s = 1'b1;
        end else begin
          ctr_inc_s  = hs_s;
        end
`else
        ctr_inc_s = hs_s;
`endif
      end
      VERIFY: begin
`ifdef RAM_LOADER_VERIFY_EN
        ctr_inc_s = 1'b1;
`else
        ctr_inc_s = 1'b0;
`endif
      end
      DONE:    ctr_inc_s = 1'b0;
      default: ctr_inc_s = 1'b0;
    endcase
  end

  ram_loader_addr_ctr #(
    .ADDR_W     (ADDR_W),
    .LOAD_COUNT (LOAD_COUNT),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (ctr_load_s),
    .inc  (ctr_inc_s),
    .addr (addr_s),
    .last (last_s)
  );

  // Session sequencer; status outputs are registered together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b0;
      done_r     <= 1'b0;
      sum_r      <= DATA_ZERO;
`ifdef RAM_LOADER_VERIFY_EN
      ro_r         <= 1'b0;
      verify_err_r <= 1'b0;
      rsum_r       <= DATA_ZERO;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LOAD;
            busy_r     <= 1'b1;
            in_ready_r <= 1'b1;
            done_r     <= 1'b0;
            sum_r      <= DATA_ZERO;
`ifdef RAM_LOADER_VERIFY_EN
            verify_err_r <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (hs_s) begin
            sum_r <= sum_r + in_data;
            if (last_s) begin
              in_ready_r <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
              state_r <= VERIFY;
              ro_r    <= 1'b1;
              rsum_r  <= DATA_ZERO;
`else
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
`endif
            end
          end
        end
        VERIFY: begin
`ifdef RAM_LOADER_VERIFY_EN
          rsum_r <= rsum_next_s;
          if (last_s) begin
            verify_err_r <= (rsum_next_s != sum_r);
            ro_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            state_r      <= DONE;
          end
`else
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b0;
`endif
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign mem_address = addr_s;

`ifdef RAM_LOADER_VERIFY_EN
  assign ro         = ro_r;
  assign verify_err = verify_err_r;
`else
  assign ro         = 1'b0;
  assign verify_err = 1'b0;
`endif

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Program loader: the write-side initiator for the 16x8 program/data RAM.
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive RAM addresses by driving mem_address, ri and the RAM write data.
- Holds the CPU off the RAM bus until done; the CPU then runs from address 0.
- Replaces hand-edited initial images for loading programs.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word width.
- LOAD_COUNT, 16, bytes per load session; legal range 1..2**ADDR_W.
- BASE_ADDR, 0, first address written; addresses wrap modulo 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load session; sampled only in IDLE.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  DATA_W  byte to write.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_address  out  ADDR_W  RAM address.
- ri  out  1  RAM write enable.
- ro  out  1  RAM read enable (verify phase only).
- mem_wdata  out  DATA_W  drives the RAM write data input.
- mem_rdata  in  DATA_W  RAM read data; used only with VERIFY_EN.
- busy  out  1  session in progress; CPU must not touch the RAM bus.
- done  out  1  level; last session completed.
- verify_err  out  1  readback checksum mismatch; constant 0 without VERIFY_EN.

Behaviour:
- Reset: state=IDLE, addr=BASE_ADDR, count=0, sum=0, done=0, verify_err=0.
- Outputs after reset: in_ready=0, ri=0, ro=0, busy=0, mem_address=BASE_ADDR, mem_wdata=0.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> LOAD; addr=BASE_ADDR, count=0, sum=0, done=0, verify_err=0.
- LOAD:
  - busy=1, in_ready=1.
  - Handshake = in_valid & in_ready.
  - ri = handshake, combinational; mem_wdata = in_data; mem_address = addr. The RAM captures the byte on the same rising edge, so latency is 0.
  - On each handshake: addr increments modulo 2**ADDR_W, count increments, and sum += in_data modulo 2**DATA_W.
  - in_valid=0 stalls the session indefinitely with ri=0.
  - On the handshake with count==LOAD_COUNT-1: go to VERIFY if VERIFY_EN is defined, else DONE.
- DONE:
  - busy=0, done=1 for one cycle in this state.
  - Next cycle -> IDLE with done held at 1 until the next accepted start.
- ri and ro are never both 1.
- mem_wdata is 0 whenever ri=0.
- start while busy is ignored.
- start and in_valid asserted in the same IDLE cycle: only the start is taken; the byte is accepted no earlier than the next cycle.
- rst mid-session: next cycle is IDLE with reset values. RAM contents already written are kept; there is no rollback.
- BASE_ADDR+LOAD_COUNT > 2**ADDR_W: writes wrap to address 0.

Optional Feature:
- Macro: RAM_LOADER_VERIFY_EN.
- Defined: adds a VERIFY state entered after the last write.
  - addr restarts at BASE_ADDR; ro=1, ri=0, in_ready=0, busy=1.
  - Each cycle: rsum += mem_rdata (combinational read), addr++.
  - After LOAD_COUNT reads: verify_err = (rsum != sum), then go to DONE.
  - Total verify time is LOAD_COUNT cycles.
- Not defined:
  - No VERIFY state, ro tied 0, verify_err tied 0.
  - mem_rdata unused.
  - LOAD goes straight to DONE.

Decomposition:
- Shared package eater_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Opcode constants (ADD, HLT, ...) used by test images.
  - Enum loader_state_t {IDLE, LOAD, VERIFY, DONE}.
- One natural sub-module: ram_loader_addr_ctr, a wrapping address counter plus session count with load/increment/terminal-count.
- Checksum accumulator stays inline.

Test Plan:
- Basic load: rst, start, stream 8'h2F, 8'hF0, then 14 more bytes with in_valid held high.
  - ri high for 16 consecutive cycles at addresses 0..15, then done=1, busy=0.
  - RAM[0]=8'h2F, RAM[1]=8'hF0.
- Back-pressure: toggle in_valid 1,0,0,1,... over 16 bytes.
  - ri only on handshake cycles; addresses contiguous; done after the 16th byte.
- Reset mid-load: rst after 5 bytes.
  - Next cycle busy=0, ri=0, mem_address=0.
  - RAM[0..4] retain the values written.
  - A new start reloads from address 0.
- Ignore rules:
  - in_valid=1 in IDLE -> in_ready=0, no ri.
  - start pulsed during LOAD -> count is unaffected.
- Wrap: BASE_ADDR=14, LOAD_COUNT=4 -> writes go to 14, 15, 0, 1.
- VERIFY_EN:
  - Clean run -> ro high for 16 cycles, verify_err=0.
  - Bench corrupts mem_rdata at address 3 (XOR 8'h01) -> verify_err=1 with done=1.
